// File: rtl/galaga_lib.sv
// Shared Galaga definitions: key codes, playfield limits, ship geometry and the missile types
// used by the player missile scheduler.
package galaga_lib;

    localparam logic [7:0] SPACE_KEY = 8'h2C;

    localparam logic [9:0] X_Min     = 10'd0;
    localparam logic [9:0] Y_Min     = 10'd0;
    localparam logic [9:0] ShipXSize = 10'd16;
    localparam logic [9:0] ShipYSize = 10'd16;

    typedef enum logic {READY, COOL} fire_state_t;

    typedef struct packed {
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
    } missile_t;

endpackage

// File: rtl/missile_slot.sv
// One missile slot: spawn on launch, retire on hit or at the top edge, otherwise climb one
// step per frame; also reports whether the current pixel falls inside this missile.
module missile_slot
    import galaga_lib::*;
#(
    parameter int MISSILE_STEP = 4,
    parameter int MISSILE_W    = 2,
    parameter int MISSILE_H    = 8
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       launch,
    input  logic [9:0] spawnX,
    input  logic [9:0] spawnY,
    input  logic       hit,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output missile_t   slot,
    output logic       pixelOn
);

    localparam logic [9:0] STEP     = 10'(MISSILE_STEP);
    localparam logic [9:0] RETIRE_Y = 10'(Y_Min + STEP);

    logic [10:0] xEnd;
    logic [10:0] yEnd;

    // NOTE: slot registers take the asynchronous reset like any other state, so a reset
    // mid-flight clears them immediately instead of waiting for a frame edge.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot <= '0;
        end else if (launch) begin
            slot <= '{act: 1'b1, x: spawnX, y: spawnY};
        end else if (slot.act) begin
            // NOTE: non-blocking assignments: every field updates from its pre-edge value.
            if (hit || slot.y < RETIRE_Y) begin
                slot.act <= 1'b0;
            end else begin
                slot.y <= slot.y - STEP;
            end
        end
    end

    // Extended by one bit so a missile hugging the right/bottom edge does not wrap its span.
    assign xEnd = {1'b0, slot.x} + 11'(MISSILE_W);
    assign yEnd = {1'b0, slot.y} + 11'(MISSILE_H);

    always_comb begin
        pixelOn = slot.act
                  && DrawX >= slot.x && {1'b0, DrawX} <= xEnd
                  && DrawY >= slot.y && {1'b0, DrawY} <= yEnd;
    end

endmodule

// File: rtl/player_missile_ctrl.sv
// Player missile scheduler: SPACE edge detect, launch cooldown FSM and lowest-free slot
// allocation, with one missile_slot per concurrent missile.
module player_missile_ctrl
    import galaga_lib::*;
#(
    parameter int N_MISSILES   = 2,
    parameter int MISSILE_STEP = 4,
    parameter int COOLDOWN     = 8,
    parameter int MISSILE_W    = 2,
    parameter int MISSILE_H    = 8
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic [15:0]             keycode,
    input  logic [9:0]              ShipX,
    input  logic [9:0]              ShipY,
    input  logic [N_MISSILES-1:0]   MissileHit,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic                    MissileOn,
    output logic [10*N_MISSILES-1:0] MissileX,
    output logic [10*N_MISSILES-1:0] MissileY,
    output logic [N_MISSILES-1:0]   MissileAct,
    output logic                    FireEvt
);

    localparam int CD_W = $clog2(COOLDOWN + 1);

    fire_state_t           state;
    logic [CD_W-1:0]       cooldown;
    logic                  spaceQ;
    logic                  spaceHeld;
    logic                  fireReq;
    logic                  spawnOk;
    logic [9:0]            spawnX;
    logic [9:0]            spawnY;
    logic                  slotFound;
    logic [N_MISSILES-1:0] launchVec;
    logic [N_MISSILES-1:0] onVec;

    assign spaceHeld = (keycode[7:0] == SPACE_KEY) || (keycode[15:8] == SPACE_KEY);
    assign fireReq   = spaceHeld && !spaceQ;

    // A ship too close to the top would spawn at a wrapped y, so such a launch is refused.
    assign spawnOk = ShipY >= 10'(MISSILE_H);
    assign spawnX  = ShipX + ShipXSize / 2 - 10'(MISSILE_W / 2);
    assign spawnY  = ShipY - 10'(MISSILE_H);

    // Lowest-index free slot wins; free/busy comes from registered act only.
    always_comb begin
        // NOTE: defaults first so every path assigns launchVec and slotFound (no latch).
        launchVec = '0;
        slotFound = 1'b0;
        for (int i = 0; i < N_MISSILES; i++) begin
            if (!MissileAct[i] && !slotFound) begin
                launchVec[i] = (state == READY) && fireReq && spawnOk;
                slotFound    = 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= READY;
            cooldown <= '0;
            spaceQ   <= 1'b0;
            FireEvt  <= 1'b0;
        end else begin
            spaceQ  <= spaceHeld;
            FireEvt <= |launchVec;
            case (state)
                READY: begin
                    if (|launchVec) begin
                        state    <= COOL;
                        cooldown <= CD_W'(COOLDOWN);
                    end
                end
                COOL: begin
                    cooldown <= cooldown - CD_W'(1);
                    if (cooldown <= CD_W'(1)) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    for (genvar i = 0; i < N_MISSILES; i++) begin : gSlot
        missile_t slot;

        missile_slot #(
            .MISSILE_STEP(MISSILE_STEP),
            .MISSILE_W   (MISSILE_W),
            .MISSILE_H   (MISSILE_H)
        ) uSlot (
            .frame_clk(frame_clk),
            .Reset_n  (Reset_n),
            .launch   (launchVec[i]),
            .spawnX   (spawnX),
            .spawnY   (spawnY),
            .hit      (MissileHit[i]),
            .DrawX    (DrawX),
            .DrawY    (DrawY),
            .slot     (slot),
            .pixelOn  (onVec[i])
        );

        assign MissileAct[i]        = slot.act;
        assign MissileX[10*i +: 10] = slot.x;
        assign MissileY[10*i +: 10] = slot.y;
    end

    assign MissileOn = |onVec;

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Scoreboarded bench for player_missile_ctrl: each frame of stimulus pushes its expected
// outcome, and a monitor pops and compares just after every frame edge.
module tb_player_missile_ctrl;
    import galaga_lib::*;

    localparam int N = 2;
    localparam logic [15:0] SP = 16'h002C;
    localparam logic [15:0] NK = 16'h0000;

    logic            frame_clk = 1'b0;
    logic            Reset_n   = 1'b0;
    logic [15:0]     keycode   = '0;
    logic [9:0]      ShipX     = 10'd320;
    logic [9:0]      ShipY     = 10'd240;
    logic [N-1:0]    MissileHit = '0;
    logic [9:0]      DrawX     = 10'd1023;
    logic [9:0]      DrawY     = 10'd1023;
    logic            MissileOn;
    logic [10*N-1:0] MissileX;
    logic [10*N-1:0] MissileY;
    logic [N-1:0]    MissileAct;
    logic            FireEvt;

    player_missile_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .ShipX     (ShipX),
        .ShipY     (ShipY),
        .MissileHit(MissileHit),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .MissileOn (MissileOn),
        .MissileX  (MissileX),
        .MissileY  (MissileY),
        .MissileAct(MissileAct),
        .FireEvt   (FireEvt)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string        name;
        logic [N-1:0] act;
        logic [19:0]  x;
        logic [19:0]  y;
        logic         fire;
        logic         on;
    } exp_t;

    exp_t sbQ[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   fireCount = 0;

    // Reference state tracked frame by frame from the behaviour description.
    logic [N-1:0] mAct;
    logic [9:0]   mX[N];
    logic [9:0]   mY[N];
    fire_state_t  mState;
    int           mCd;
    logic         mSpaceQ;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (FireEvt === 1'b1) fireCount++;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                check({e.name, ".act"},  32'(MissileAct), 32'(e.act));
                check({e.name, ".x"},    32'(MissileX),   32'(e.x));
                check({e.name, ".y"},    32'(MissileY),   32'(e.y));
                check({e.name, ".fire"}, 32'(FireEvt),    32'(e.fire));
                check({e.name, ".on"},   32'(MissileOn),  32'(e.on));
            end
        end
    end

    function automatic logic [9:0] slotX(input int i);
        return MissileX[10*i +: 10];
    endfunction

    function automatic logic [9:0] slotY(input int i);
        return MissileY[10*i +: 10];
    endfunction

    task automatic resetModel();
        mAct    = '0;
        mState  = READY;
        mCd     = 0;
        mSpaceQ = 1'b0;
        for (int i = 0; i < N; i++) begin
            mX[i] = '0;
            mY[i] = '0;
        end
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic pulseReset(input string name);
        #1;
        Reset_n = 1'b0;
        #1;
        check({name, ".act"},  32'(MissileAct), 32'd0);
        check({name, ".fire"}, 32'(FireEvt),    32'd0);
        check({name, ".y"},    32'(MissileY),   32'd0);
        resetModel();
        keycode    = NK;
        MissileHit = '0;
        @(negedge frame_clk);
        Reset_n = 1'b1;
    endtask

    task automatic frame(input string name, input logic [15:0] key, input logic [N-1:0] hit,
                         input logic [9:0] dx, input logic [9:0] dy);
        exp_t e;
        logic held;
        logic req;
        int   ls;
        @(negedge frame_clk);
        keycode    = key;
        MissileHit = hit;
        DrawX      = dx;
        DrawY      = dy;
        held = (key[7:0] == SPACE_KEY) || (key[15:8] == SPACE_KEY);
        req  = held && !mSpaceQ;
        ls   = -1;
        if (mState == READY && req && ShipY >= 10'd8) begin
            for (int i = 0; i < N; i++) begin
                if (!mAct[i] && ls < 0) ls = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == ls) begin
                mAct[i] = 1'b1;
                mX[i]   = ShipX + 10'd8 - 10'd1;
                mY[i]   = ShipY - 10'd8;
            end else if (mAct[i]) begin
                if (hit[i] || mY[i] < 10'd4) mAct[i] = 1'b0;
                else mY[i] = mY[i] - 10'd4;
            end
        end
        if (ls >= 0) begin
            mState = COOL;
            mCd    = 8;
        end else if (mState == COOL) begin
            mCd--;
            if (mCd == 0) mState = READY;
        end
        mSpaceQ = held;
        e.name = name;
        e.act  = mAct;
        e.fire = (ls >= 0);
        e.on   = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.x[10*i +: 10] = mX[i];
            e.y[10*i +: 10] = mY[i];
            if (mAct[i] && int'(dx) >= int'(mX[i]) && int'(dx) <= int'(mX[i]) + 2
                        && int'(dy) >= int'(mY[i]) && int'(dy) <= int'(mY[i]) + 8)
                e.on = 1'b1;
        end
        sbQ.push_back(e);
        @(posedge frame_clk);
        #2;
    endtask

    initial begin : stimulus
        resetModel();
        #2;
        check("rst_init.act", 32'(MissileAct), 32'd0);
        check("rst_init.fire", 32'(FireEvt), 32'd0);
        check("rst_init.on", 32'(MissileOn), 32'd0);
        check("rst_init.x", 32'(MissileX), 32'd0);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        // Single launch from (320,240) and its first step.
        frame("launch", SP, '0, 10'd327, 10'd232);
        check("launch.x0", 32'(slotX(0)), 32'd327);
        check("launch.y0", 32'(slotY(0)), 32'd232);
        check("launch.evt", 32'(FireEvt), 32'd1);
        frame("step", NK, '0, 10'd1023, 10'd1023);
        check("step.y0", 32'(slotY(0)), 32'd228);
        check("step.evt", 32'(FireEvt), 32'd0);

        pulseReset("rst_mid");

        // Held SPACE fires once; cooldown, busy and reuse cases follow.
        fireCount = 0;
        repeat (20) frame("hold", SP, '0, 10'd1023, 10'd1023);
        check("hold.shots", 32'(fireCount), 32'd1);
        frame("rel", NK, '0, 10'd1023, 10'd1023);
        frame("press_slot1", SP, '0, 10'd1023, 10'd1023);
        check("press_slot1.act", 32'(MissileAct), 32'b11);
        check("press_slot1.y1", 32'(slotY(1)), 32'd232);
        frame("rel", NK, '0, 10'd1023, 10'd1023);
        frame("rel", NK, '0, 10'd1023, 10'd1023);
        frame("press_cool", SP, '0, 10'd1023, 10'd1023);
        check("press_cool.evt", 32'(FireEvt), 32'd0);
        repeat (4) frame("rel", NK, '0, 10'd1023, 10'd1023);
        frame("press_cd0", SP, '0, 10'd1023, 10'd1023);
        check("press_cd0.evt", 32'(FireEvt), 32'd0);
        frame("rel", NK, '0, 10'd1023, 10'd1023);
        frame("press_busy", SP, '0, 10'd1023, 10'd1023);
        check("press_busy.evt", 32'(FireEvt), 32'd0);
        frame("hit0", NK, 2'b01, 10'd1023, 10'd1023);
        check("hit0.act", 32'(MissileAct), 32'b10);
        frame("reuse0", SP, '0, 10'd1023, 10'd1023);
        check("reuse0.act", 32'(MissileAct), 32'b11);
        check("reuse0.y0", 32'(slotY(0)), 32'd232);

        // Pixel hit-test around a missile spawned at (327,92).
        pulseReset("rst_pix");
        ShipY = 10'd100;
        frame("pix_corner", SP, '0, 10'd327, 10'd92);
        check("pix_corner.on", 32'(MissileOn), 32'd1);
        frame("pix_right", NK, '0, 10'd330, 10'd88);
        check("pix_right.on", 32'(MissileOn), 32'd0);
        frame("pix_in", NK, '0, 10'd329, 10'd92);
        check("pix_in.on", 32'(MissileOn), 32'd1);
        frame("pix_below", NK, '0, 10'd327, 10'd89);

        // Top-edge retire without wrap.
        pulseReset("rst_edge");
        ShipY = 10'd13;
        frame("edge_launch", SP, '0, 10'd1023, 10'd1023);
        check("edge_launch.y0", 32'(slotY(0)), 32'd5);
        frame("edge_step", NK, '0, 10'd1023, 10'd1023);
        check("edge_step.y0", 32'(slotY(0)), 32'd1);
        frame("edge_retire", NK, '0, 10'd1023, 10'd1023);
        check("edge_retire.act", 32'(MissileAct), 32'd0);
        check("edge_retire.y0", 32'(slotY(0)), 32'd1);

        // Spawn-wrap guard and its exact boundary.
        pulseReset("rst_low");
        ShipY = 10'd4;
        frame("low_ship", SP, '0, 10'd1023, 10'd1023);
        check("low_ship.act", 32'(MissileAct), 32'd0);
        frame("rel", NK, '0, 10'd1023, 10'd1023);
        ShipY = 10'd8;
        frame("ship_at_h", SP, '0, 10'd327, 10'd0);
        check("ship_at_h.evt", 32'(FireEvt), 32'd1);
        frame("ship_at_h_retire", NK, '0, 10'd1023, 10'd1023);
        check("ship_at_h_retire.act", 32'(MissileAct), 32'd0);

        #3;
        check("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
